// File: rtl/div_iterative_if.sv
`default_nettype none
// ============================================================================
// Module      : div_iterative_if
// Description : Request/response bundle for the iterative divider.
//               The master side issues operands; the slave side returns the
//               quotient, remainder and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_iterative_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;
  logic             div_by_zero_o;

  modport master (
    output start_i, signed_i, dividend_i, divisor_i,
    input  busy_o, done_o, quotient_o, remainder_o, div_by_zero_o
  );

  modport slave (
    input  start_i, signed_i, dividend_i, divisor_i,
    output busy_o, done_o, quotient_o, remainder_o, div_by_zero_o
  );
endinterface
`default_nettype wire

// File: rtl/div_iterative.sv
`default_nettype none
// ============================================================================
// Module      : div_iterative
// Description : Multi-cycle restoring divider with RISC-V DIV/DIVU/REM/REMU
//               semantics. Works on magnitudes, one quotient bit per cycle,
//               and fixes up signs when the result is written out.
// Revision    : 1.0 - initial release
// ============================================================================
module div_iterative #(
  parameter int WIDTH = 32
) (
  input  wire logic       clk_i,
  input  wire logic       rst_i,
  div_iterative_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0]       C_IDLE     = 2'd0;
  localparam logic [1:0]       C_CALC     = 2'd1;
  localparam logic [1:0]       C_DONE     = 2'd2;
  localparam logic [WIDTH-1:0] C_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    C_CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]    C_CNT_ONE  = CW'(1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_qneg;
  logic             r_rneg;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_done;
  logic             r_dbz;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic             w_div_zero;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_dvs_inv;
  logic [WIDTH+1:0] w_c;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic [WIDTH-1:0] w_quo_fin;
  logic [WIDTH-1:0] w_rem_fin;

  // Operand signs are only meaningful in signed mode; magnitudes feed the core.
  assign w_dvd_neg  = bus.signed_i & bus.dividend_i[WIDTH-1];
  assign w_dvs_neg  = bus.signed_i & bus.divisor_i[WIDTH-1];
  assign w_div_zero = (bus.divisor_i == '0);
  assign w_dvd_mag  = w_dvd_neg ? (~bus.dividend_i + C_ONE) : bus.dividend_i;
  assign w_dvs_mag  = w_dvs_neg ? (~bus.divisor_i  + C_ONE) : bus.divisor_i;

  // Shifted remainder needs WIDTH+1 bits: an unsigned divisor can use all
  // WIDTH bits, so twice the running remainder can overflow WIDTH.
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_dvs_inv = ~{1'b0, r_dvs};
  assign w_c[0]    = 1'b1;

  // Trial subtraction as a ripple add of the inverted divisor, carry-in 1.
  generate
    for (genvar i = 0; i <= WIDTH; i++) begin : g_carry
      assign w_c[i+1] = (w_shift[i] & w_dvs_inv[i]) |
                        (w_c[i] & (w_shift[i] ^ w_dvs_inv[i]));
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_sum
      assign w_sum[i] = w_shift[i] ^ w_dvs_inv[i] ^ w_c[i];
    end
  endgenerate

  // Carry-out set means no borrow: the divisor fits, keep the difference.
  assign w_carry    = w_c[WIDTH+1];
  assign w_rem_next = w_carry ? w_sum : w_shift[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_carry};
  assign w_quo_fin  = r_qneg ? (~w_quo_next + C_ONE) : w_quo_next;
  assign w_rem_fin  = r_rneg ? (~w_rem_next + C_ONE) : w_rem_next;

  // Control FSM plus iteration datapath; results only update on entering DONE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= C_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        C_IDLE, C_DONE: begin
          if (bus.start_i) begin
            r_qneg <= w_dvd_neg ^ w_dvs_neg;
            r_rneg <= w_dvd_neg;
            r_quo  <= w_dvd_mag;
            r_dvs  <= w_dvs_mag;
            r_rem  <= '0;
            r_cnt  <= C_CNT_INIT;
            if (w_div_zero) begin
              r_state     <= C_DONE;
              r_done      <= 1'b1;
              r_quotient  <= '1;
              r_remainder <= bus.dividend_i;
              r_dbz       <= 1'b1;
            end else begin
              r_state <= C_CALC;
            end
          end else begin
            r_state <= C_IDLE;
          end
        end
        C_CALC: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt - C_CNT_ONE;
          if (r_cnt == C_CNT_ONE) begin
            r_state     <= C_DONE;
            r_done      <= 1'b1;
            r_quotient  <= w_quo_fin;
            r_remainder <= w_rem_fin;
            r_dbz       <= 1'b0;
          end
        end
        default: r_state <= C_IDLE;
      endcase
    end
  end

  assign bus.busy_o        = (r_state == C_CALC);
  assign bus.done_o        = r_done;
  assign bus.quotient_o    = r_quotient;
  assign bus.remainder_o   = r_remainder;
  assign bus.div_by_zero_o = r_dbz;
endmodule
`default_nettype wire
